// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, interrupt cause codes, mstatus bit positions, CSR op encodings, trap FSM states
package csr_pkg;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;
  typedef enum logic {RUN, FLUSH} state_t;
endpackage

// File: rtl/csr_trap_unit_counter64.sv
// csr_counter64: 64-bit free-running counter with independent 32-bit half writes (built only with CSR_COUNTERS_EN)
//   clk, reset            : clock, synchronous active-high reset
//   i_inc                 : add one this cycle
//   i_we_lo / i_we_hi     : load i_wdata into the low / high half (overrides the increment for that half)
//   o_value               : current count
`ifdef CSR_COUNTERS_EN
module csr_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_inc,
  input  logic        i_we_lo,
  input  logic        i_we_hi,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_value
);
  logic [63:0] r_value;
  logic [63:0] w_next;
  assign w_next  = r_value + {63'b0, i_inc};
  assign o_value = r_value;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_value <= 64'b0;
    end else begin
      r_value[31:0]  <= i_we_lo ? i_wdata : w_next[31:0];
      r_value[63:32] <= i_we_hi ? i_wdata : (i_we_lo ? r_value[63:32] : w_next[63:32]);
    end
  end
endmodule
`endif

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file and interrupt/MRET trap sequencer at commit
//   inputs : clk, reset, instr_valid, pc, is_csr_instr, is_mret_instr, csr_write, csr_data_sel,
//            func3, csr_addr, rs1_data, zimm, irq_ext, irq_timer, irq_sw
//   outputs: csr_rdata (combinational old value), redirect (registered pulse), redirect_pc, illegal_csr
//   macro  : CSR_COUNTERS_EN adds mcycle/minstret (0xB00/0xB80, 0xB02/0xB82)
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] pc,
  input  logic        is_csr_instr,
  input  logic        is_mret_instr,
  input  logic        csr_write,
  input  logic        csr_data_sel,
  input  logic [2:0]  func3,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  zimm,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        irq_sw,
  output logic [31:0] csr_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        illegal_csr
);
  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_mie_bit, r_mpie, r_redirect;
  logic [31:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mip, r_redirect_pc;
  logic [31:0] w_src, w_new, w_mstatus, w_pend_bits, w_base, w_vec;
  logic [3:0]  w_code;
  logic        w_int_pend, w_trap, w_mret, w_we, w_known, w_unused;
  assign w_unused    = func3[2];
  assign w_mstatus   = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie_bit, 3'b0};
  assign w_pend_bits = r_mie & r_mip;
  assign w_int_pend  = r_mie_bit & |w_pend_bits;
  assign w_code      = w_pend_bits[11] ? CAUSE_MEI : (w_pend_bits[3] ? CAUSE_MSI : CAUSE_MTI);
  assign w_trap      = (r_state == RUN) && w_int_pend && instr_valid && (r_cnt == 3'd0);
  assign w_mret      = (r_state == RUN) && instr_valid && is_mret_instr && !w_trap;
  assign w_base      = {r_mtvec[31:2], 2'b00};
  assign w_vec       = r_mtvec[0] ? w_base + {26'b0, w_code, 2'b00} : w_base;
  assign w_src       = csr_data_sel ? {27'b0, zimm} : rs1_data;
  assign w_new       = func3[1:0] == OP_RW ? w_src : (func3[1:0] == OP_RS ? csr_rdata | w_src : csr_rdata & ~w_src);
  // set/clear with a zero source is a pure read
  assign w_we        = instr_valid & is_csr_instr & csr_write & !w_trap &
                       ((func3[1:0] == OP_RW) | ((func3[1:0] != 2'b00) & |w_src));
  assign illegal_csr = is_csr_instr & instr_valid & !w_known;
  assign redirect    = r_redirect;
  assign redirect_pc = r_redirect_pc;
`ifdef CSR_COUNTERS_EN
  logic [63:0] w_mcycle, w_minstret;
  csr_counter64 u_mcycle (
    .clk(clk), .reset(reset), .i_inc(1'b1),
    .i_we_lo(w_we && csr_addr == CSR_MCYCLE), .i_we_hi(w_we && csr_addr == CSR_MCYCLEH),
    .i_wdata(w_new), .o_value(w_mcycle)
  );
  csr_counter64 u_minstret (
    .clk(clk), .reset(reset), .i_inc(instr_valid & !w_trap),
    .i_we_lo(w_we && csr_addr == CSR_MINSTRET), .i_we_hi(w_we && csr_addr == CSR_MINSTRETH),
    .i_wdata(w_new), .o_value(w_minstret)
  );
`endif
  always_comb begin
    csr_rdata = 32'h0;
    w_known   = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:   csr_rdata = w_mstatus;
      CSR_MIE:       csr_rdata = r_mie;
      CSR_MTVEC:     csr_rdata = r_mtvec;
      CSR_MSCRATCH:  csr_rdata = r_mscratch;
      CSR_MEPC:      csr_rdata = r_mepc;
      CSR_MCAUSE:    csr_rdata = r_mcause;
      CSR_MIP:       csr_rdata = r_mip;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    csr_rdata = w_mcycle[31:0];
      CSR_MCYCLEH:   csr_rdata = w_mcycle[63:32];
      CSR_MINSTRET:  csr_rdata = w_minstret[31:0];
      CSR_MINSTRETH: csr_rdata = w_minstret[63:32];
`else
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: csr_rdata = 32'h0;
`endif
      default:       w_known = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RUN;
      r_cnt         <= 3'd0;
      r_mie_bit     <= 1'b0;
      r_mpie        <= 1'b0;
      r_mie         <= 32'h0;
      r_mtvec       <= MTVEC_RESET;
      r_mscratch    <= 32'h0;
      r_mepc        <= 32'h0;
      r_mcause      <= 32'h0;
      r_mip         <= 32'h0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= 32'h0;
    end else begin
      r_mip      <= {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};
      r_redirect <= w_trap | w_mret;
      if (w_trap) r_redirect_pc <= w_vec;
      else if (w_mret) r_redirect_pc <= r_mepc;
      if (w_we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            r_mie_bit <= w_new[MSTATUS_MIE];
            r_mpie    <= w_new[MSTATUS_MPIE];
          end
          CSR_MIE:      r_mie      <= w_new & 32'h0000_0888;
          CSR_MTVEC:    r_mtvec    <= w_new & ~32'h2;
          CSR_MSCRATCH: r_mscratch <= w_new;
          CSR_MEPC:     r_mepc     <= {w_new[31:2], 2'b00};
          CSR_MCAUSE:   r_mcause   <= w_new;
          default: ;
        endcase
      end
      if (w_trap) begin
        r_mepc    <= {pc[31:2], 2'b00};
        r_mcause  <= {1'b1, 27'b0, w_code};
        r_mpie    <= r_mie_bit;
        r_mie_bit <= 1'b0;
      end else if (w_mret) begin
        r_mie_bit <= r_mpie;
        r_mpie    <= 1'b1;
      end
      if (w_trap | w_mret) begin
        r_state <= FLUSH;
        r_cnt   <= 3'(FLUSH_CYCLES - 1);
      end else if (r_state == FLUSH) begin
        if (r_cnt == 3'd0) r_state <= RUN;
        else r_cnt <= r_cnt - 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: scoreboard bench for csr_trap_unit (CSR ops, interrupts, MRET, flush window)
module tb_csr_trap_unit;
  import csr_pkg::*;
  localparam int FC = 2;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0, is_csr_instr = 1'b0, is_mret_instr = 1'b0, csr_write = 1'b0, csr_data_sel = 1'b0;
  logic [31:0] pc = 32'h0, rs1_data = 32'h0;
  logic [2:0]  func3 = 3'b0;
  logic [11:0] csr_addr = 12'h0;
  logic [4:0]  zimm = 5'h0;
  logic        irq_ext = 1'b0, irq_timer = 1'b0, irq_sw = 1'b0;
  logic [31:0] csr_rdata, redirect_pc;
  logic        redirect, illegal_csr;
  int          passed = 0, total = 0;
  logic [31:0] exp_rd[$];
  logic [31:0] exp_pc[$];
  logic [31:0] e;
  bit          seen;

  csr_trap_unit #(.MTVEC_RESET(32'h0), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .pc(pc),
    .is_csr_instr(is_csr_instr), .is_mret_instr(is_mret_instr), .csr_write(csr_write),
    .csr_data_sel(csr_data_sel), .func3(func3), .csr_addr(csr_addr), .rs1_data(rs1_data),
    .zimm(zimm), .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_sw(irq_sw),
    .csr_rdata(csr_rdata), .redirect(redirect), .redirect_pc(redirect_pc), .illegal_csr(illegal_csr)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic csr, input logic mret, input logic we, input logic sel, input logic [2:0] f3,
                       input logic [11:0] a, input logic [31:0] rs1, input logic [4:0] z, input logic [31:0] p);
    @(posedge clk); #1;
    instr_valid = 1'b1; is_csr_instr = csr; is_mret_instr = mret; csr_write = we; csr_data_sel = sel;
    func3 = f3; csr_addr = a; rs1_data = rs1; zimm = z; pc = p;
    @(negedge clk);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] p);
    issue(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, a, 32'h0, 5'h0, p);
  endtask

  task automatic wait_redirect(output bit s);
    @(posedge clk); #1;
    instr_valid = 1'b0; is_csr_instr = 1'b0; is_mret_instr = 1'b0; csr_write = 1'b0;
    s = 1'b0;
    for (int i = 0; i < 6 && !s; i++) begin
      @(negedge clk);
      s = redirect;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (redirect !== 1'b0) $display("FAIL reset_redirect got=%b exp=0", redirect); else passed++;
    total++; if (redirect_pc !== 32'h0) $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc); else passed++;
    @(posedge clk); #1 reset = 1'b0;
`ifdef CSR_COUNTERS_EN
    repeat (9) @(posedge clk);
    exp_rd.push_back(32'd10); rd(CSR_MCYCLE, 32'h0);
    e = exp_rd.pop_front(); total++; if (csr_rdata !== e) $display("FAIL mcycle_after_reset got=%h exp=%h", csr_rdata, e); else passed++;
`endif
    exp_rd.push_back(32'h0000_1800); rd(CSR_MSTATUS, 32'h0);
    e = exp_rd.pop_front(); total++; if (csr_rdata !== e) $display("FAIL reset_mstatus got=%h exp=%h", csr_rdata, e); else passed++;
    total++; if (illegal_csr !== 1'b0) $display("FAIL reset_illegal got=%b exp=0", illegal_csr); else passed++;
    exp_rd.push_back(32'h0); rd(CSR_MTVEC, 32'h0);
    e = exp_rd.pop_front(); total++; if (csr_rdata !== e) $display("FAIL reset_mtvec got=%h exp=%h", csr_rdata, e); else passed++;
    exp_rd.push_back(32'h0); rd(CSR_MCAUSE, 32'h0);
    e = exp_rd.pop_front(); total++; if (csr_rdata !== e) $display("FAIL reset_mcause got=%h exp=%h", csr_rdata, e); else passed++;
  endtask

  task automatic test_csr_ops();
    exp_rd.push_back(32'h0); issue(1, 0, 1, 0, 3'b001, CSR_MSCRATCH, 32'hDEADBEEF, 5'h0, 32'h4);
    e = exp_rd.pop_front(); total++; if (csr_rdata !== e) $display("FAIL csrrw_old got=%h exp=%h", csr_rdata, e); else passed++;
    exp_rd.push_back(32'hDEADBEEF); issue(1, 0, 1, 1, 3'b110, CSR_MSCRATCH, 32'h0, 5'h0, 32'h8);
    e = exp_rd.pop_front(); total++; if (csr_rdata !== e) $display("FAIL csrrsi_zero got=%h exp=%h", csr_rdata, e); else passed++;
    exp_rd.push_back(32'hDEADBEEF); issue(1, 0, 1, 0, 3'b011, CSR_MSCRATCH, 32'h0000_00FF, 5'h0, 32'hC);
    e = exp_rd.pop_front(); total++; if (csr_rdata !== e) $display("FAIL csrrc_old got=%h exp=%h", csr_rdata, e); else passed++;
    exp_rd.push_back(32'hDEADBE00); rd(CSR_MSCRATCH, 32'h10);
    e = exp_rd.pop_front(); total++; if (csr_rdata !== e) $display("FAIL csrrc_result got=%h exp=%h", csr_rdata, e); else passed++;
    issue(1, 0, 1, 0, 3'b001, CSR_MEPC, 32'h0000_0123, 5'h0, 32'h14);
    exp_rd.push_back(32'h0000_0120); rd(CSR_MEPC, 32'h18);
    e = exp_rd.pop_front(); total++; if (csr_rdata !== e) $display("FAIL mepc_align got=%h exp=%h", csr_rdata, e); else passed++;
    issue(1, 0, 1, 0, 3'b001, CSR_MTVEC, 32'h0000_0103, 5'h0, 32'h1C);
    exp_rd.push_back(32'h0000_0101); rd(CSR_MTVEC, 32'h20);
    e = exp_rd.pop_front(); total++; if (csr_rdata !== e) $display("FAIL mtvec_bit1 got=%h exp=%h", csr_rdata, e); else passed++;
  endtask

  task automatic test_irq_ext();
    exp_rd.push_back(32'h0000_0101); issue(1, 0, 1, 0, 3'b001, CSR_MTVEC, 32'h100, 5'h0, 32'h24);
    e = exp_rd.pop_front(); total++; if (csr_rdata !== e) $display("FAIL mtvec_old got=%h exp=%h", csr_rdata, e); else passed++;
    issue(1, 0, 1, 0, 3'b001, CSR_MIE, 32'h800, 5'h0, 32'h28);
    irq_ext = 1'b1;
    issue(1, 0, 1, 1, 3'b110, CSR_MSTATUS, 32'h0, 5'h8, 32'h2C);
    exp_pc.push_back(32'h100);
    issue(0, 0, 0, 0, 3'b000, 12'h0, 32'h0, 5'h0, 32'h40);
    wait_redirect(seen);
    e = exp_pc.pop_front(); total++; if (!seen || redirect_pc !== e) $display("FAIL irq_ext_redirect seen=%b got=%h exp=%h", seen, redirect_pc, e); else passed++;
    @(negedge clk);
    total++; if (redirect !== 1'b0) $display("FAIL redirect_single_cycle got=%b exp=0", redirect); else passed++;
    exp_rd.push_back(32'h40); rd(CSR_MEPC, 32'h100);
    e = exp_rd.pop_front(); total++; if (csr_rdata !== e) $display("FAIL irq_mepc got=%h exp=%h", csr_rdata, e); else passed++;
    exp_rd.push_back(32'h8000_000B); rd(CSR_MCAUSE, 32'h104);
    e = exp_rd.pop_front(); total++; if (csr_rdata !== e) $display("FAIL irq_mcause got=%h exp=%h", csr_rdata, e); else passed++;
    exp_rd.push_back(32'h0000_1880); rd(CSR_MSTATUS, 32'h108);
    e = exp_rd.pop_front(); total++; if (csr_rdata !== e) $display("FAIL irq_mstatus got=%h exp=%h", csr_rdata, e); else passed++;
  endtask

  task automatic test_mret_flush();
    exp_pc.push_back(32'h40);
    issue(0, 1, 0, 0, 3'b000, 12'h0, 32'h0, 5'h0, 32'h60);
    for (int k = 0; k <= FC; k++) begin
      exp_rd.push_back(32'h0000_1888);
      rd(CSR_MSTATUS, 32'h64 + 32'(4 * k));
      e = exp_rd.pop_front(); total++; if (csr_rdata !== e) $display("FAIL mret_mstatus k=%0d got=%h exp=%h", k, csr_rdata, e); else passed++;
      if (k == 0) begin
        e = exp_pc.pop_front(); total++;
        if (redirect !== 1'b1 || redirect_pc !== e) $display("FAIL mret_redirect r=%b got=%h exp=%h", redirect, redirect_pc, e); else passed++;
      end else begin
        total++; if (redirect !== 1'b0) $display("FAIL flush_no_trap k=%0d got=%b exp=0", k, redirect); else passed++;
      end
    end
    exp_pc.push_back(32'h100);
    wait_redirect(seen);
    e = exp_pc.pop_front(); total++; if (!seen || redirect_pc !== e) $display("FAIL post_flush_trap seen=%b got=%h exp=%h", seen, redirect_pc, e); else passed++;
    @(negedge clk);
    exp_rd.push_back(32'h64 + 32'(4 * FC)); rd(CSR_MEPC, 32'h100);
    e = exp_rd.pop_front(); total++; if (csr_rdata !== e) $display("FAIL post_flush_mepc got=%h exp=%h", csr_rdata, e); else passed++;
  endtask

  task automatic test_vectored();
    irq_ext = 1'b0;
    exp_rd.push_back(32'h100); issue(1, 0, 1, 0, 3'b001, CSR_MTVEC, 32'h201, 5'h0, 32'h110);
    e = exp_rd.pop_front(); total++; if (csr_rdata !== e) $display("FAIL vec_mtvec_old got=%h exp=%h", csr_rdata, e); else passed++;
    issue(1, 0, 1, 0, 3'b001, CSR_MIE, 32'h888, 5'h0, 32'h114);
    irq_sw = 1'b1; irq_timer = 1'b1;
    issue(1, 0, 1, 1, 3'b110, CSR_MSTATUS, 32'h0, 5'h8, 32'h118);
    exp_rd.push_back(32'h88); exp_pc.push_back(32'h20C);
    rd(CSR_MIP, 32'h90);
    e = exp_rd.pop_front(); total++; if (csr_rdata !== e) $display("FAIL mip_read got=%h exp=%h", csr_rdata, e); else passed++;
    wait_redirect(seen);
    e = exp_pc.pop_front(); total++; if (!seen || redirect_pc !== e) $display("FAIL vectored_redirect seen=%b got=%h exp=%h", seen, redirect_pc, e); else passed++;
    @(negedge clk);
    exp_rd.push_back(32'h8000_0003); rd(CSR_MCAUSE, 32'h20C);
    e = exp_rd.pop_front(); total++; if (csr_rdata !== e) $display("FAIL msi_priority_cause got=%h exp=%h", csr_rdata, e); else passed++;
  endtask

  task automatic test_irq_vs_mret();
    irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b1;
    exp_rd.push_back(32'h0000_1880); issue(1, 0, 1, 1, 3'b110, CSR_MSTATUS, 32'h0, 5'h8, 32'h7C);
    e = exp_rd.pop_front(); total++; if (csr_rdata !== e) $display("FAIL mie_enable_old got=%h exp=%h", csr_rdata, e); else passed++;
    exp_pc.push_back(32'h22C);
    issue(0, 1, 0, 0, 3'b000, 12'h0, 32'h0, 5'h0, 32'h80);
    total++; if (redirect !== 1'b0) $display("FAIL no_trap_on_mie_write got=%b exp=0", redirect); else passed++;
    wait_redirect(seen);
    e = exp_pc.pop_front(); total++; if (!seen || redirect_pc !== e) $display("FAIL irq_over_mret seen=%b got=%h exp=%h", seen, redirect_pc, e); else passed++;
    @(negedge clk);
    irq_ext = 1'b0;
    exp_rd.push_back(32'h80); rd(CSR_MEPC, 32'h22C);
    e = exp_rd.pop_front(); total++; if (csr_rdata !== e) $display("FAIL irq_mret_mepc got=%h exp=%h", csr_rdata, e); else passed++;
    exp_rd.push_back(32'h0000_1880); rd(CSR_MSTATUS, 32'h230);
    e = exp_rd.pop_front(); total++; if (csr_rdata !== e) $display("FAIL mret_squashed got=%h exp=%h", csr_rdata, e); else passed++;
  endtask

  task automatic test_illegal();
    exp_rd.push_back(32'h0); issue(1, 0, 1, 0, 3'b001, 12'h7C0, 32'h1234, 5'h0, 32'h300);
    e = exp_rd.pop_front(); total++; if (csr_rdata !== e) $display("FAIL unimpl_rdata got=%h exp=%h", csr_rdata, e); else passed++;
    total++; if (illegal_csr !== 1'b1) $display("FAIL unimpl_illegal got=%b exp=1", illegal_csr); else passed++;
    rd(CSR_MCYCLE, 32'h304);
    total++; if (illegal_csr !== 1'b0) $display("FAIL counter_not_illegal got=%b exp=0", illegal_csr); else passed++;
`ifndef CSR_COUNTERS_EN
    total++; if (csr_rdata !== 32'h0) $display("FAIL counter_disabled_rdata got=%h exp=0", csr_rdata); else passed++;
`endif
    @(posedge clk); #1 instr_valid = 1'b0; is_csr_instr = 1'b1;
    @(negedge clk);
    total++; if (illegal_csr !== 1'b0) $display("FAIL illegal_needs_valid got=%b exp=0", illegal_csr); else passed++;
    is_csr_instr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_csr_ops();
    test_irq_ext();
    test_mret_flush();
    test_vectored();
    test_irq_vs_mret();
    test_illegal();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
